datapath: RTL and testbench

- 32-bit single-bus CPU datapath for the phase-1 processor.
- Contains PC, IR, Y, Z (low word), MAR, MDR, general registers R3/R4/R5/R7 and a combinational ALU.
- All transfers go over one shared 32-bit bus. Drivers are selected by *out strobes; registers capture from the bus on clock edges when their *in strobes are high.
- Control signals come from an external control sequencer, one micro-step per clock.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/datapath_alu.sv | 39 +++
 rtl/datapath.sv | 130 +++++++++++++
 tb/tb_datapath.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared widths, opcode field position and ALU opcode encodings for the single-bus datapath.
package datapath_pkg;

  localparam int DATA_W  = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_W   = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; IncPC forces B+1.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              inc_pc,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt_s;

  assign shamt_s = b[4:0];

  // Operation decode; unknown opcodes pass B through unchanged
  always_comb begin
    result = b;
    if (inc_pc) begin
      result = b + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      case (opcode)
        OP_ADD:  result = a + b;
        OP_SUB:  result = a - b;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_SHR:  result = a >> shamt_s;
        OP_SHRA: result = $unsigned($signed(a) >>> shamt_s);
        OP_SHL:  result = a << shamt_s;
        OP_ROR:  result = (a >> shamt_s) | (a << (6'd32 - {1'b0, shamt_s}));
        OP_ROL:  result = (a << shamt_s) | (a >> (6'd32 - {1'b0, shamt_s}));
        OP_NEG:  result = {DATA_W{1'b0}} - b;
        OP_NOT:  result = ~b;
        default: result = b;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: PC, IR, Y, Zlo, MAR, MDR, R3/R4/R5/R7, priority bus mux and ALU.
// Define BUS_ONEHOT_CHECK_EN to compile in a simulation-only check for multiple bus drivers.
`ifdef BUS_ONEHOT_CHECK_EN
module datapath_bus_chk (
  input logic       clock,
  input logic       clear,
  input logic [9:0] outs
);

  // Report contention on the shared bus at each active edge
  always @(posedge clock) begin
    if (clear && ($countones(outs) > 1)) begin
      $error("datapath: %0d bus drivers active (%b)", $countones(outs), outs);
    end
  end

endmodule
`endif

module datapath
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              RZoutLo,
  input  logic              RYout,
  input  logic              IRout,
  input  logic              MARout,
  input  logic              R3out,
  input  logic              R4out,
  input  logic              R5out,
  input  logic              R7out,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              MARin,
  input  logic              IRin,
  input  logic              RYin,
  input  logic              RZinLo,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              R7in,
  input  logic              IncPC,
  input  logic              MDRread,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] pc_r, ir_r, y_r, zlo_r, mar_r, mdr_r;
  logic [DATA_W-1:0] r3_r, r4_r, r5_r, r7_r;
  logic [DATA_W-1:0] alu_s;
  logic [OPC_W-1:0]  opcode_s;

  assign opcode_s = ir_r[OPC_MSB -: OPC_W];

  // Fixed-priority bus source select; an undriven bus reads zero
  always_comb begin
    bus = {DATA_W{1'b0}};
    if (MDRout) begin
      bus = mdr_r;
    end else if (PCout) begin
      bus = pc_r;
    end else if (RZoutLo) begin
      bus = zlo_r;
    end else if (RYout) begin
      bus = y_r;
    end else if (IRout) begin
      bus = ir_r;
    end else if (MARout) begin
      bus = mar_r;
    end else if (R3out) begin
      bus = r3_r;
    end else if (R4out) begin
      bus = r4_r;
    end else if (R5out) begin
      bus = r5_r;
    end else if (R7out) begin
      bus = r7_r;
    end else begin
      bus = {DATA_W{1'b0}};
    end
  end

  datapath_alu u_alu (
    .a      (y_r),
    .b      (bus),
    .opcode (opcode_s),
    .inc_pc (IncPC),
    .result (alu_s)
  );

  // Register bank: every load samples the pre-edge bus, so read-and-load of one register holds it
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_r  <= {DATA_W{1'b0}};
      ir_r  <= {DATA_W{1'b0}};
      y_r   <= {DATA_W{1'b0}};
      zlo_r <= {DATA_W{1'b0}};
      mar_r <= {DATA_W{1'b0}};
      mdr_r <= {DATA_W{1'b0}};
      r3_r  <= {DATA_W{1'b0}};
      r4_r  <= {DATA_W{1'b0}};
      r5_r  <= {DATA_W{1'b0}};
      r7_r  <= {DATA_W{1'b0}};
    end else begin
      if (PCin)   pc_r  <= bus;
      if (IRin)   ir_r  <= bus;
      if (RYin)   y_r   <= bus;
      if (RZinLo) zlo_r <= alu_s;
      if (MARin)  mar_r <= bus;
      if (MDRin)  mdr_r <= MDRread ? Mdatain : bus;
      if (R3in)   r3_r  <= bus;
      if (R4in)   r4_r  <= bus;
      if (R5in)   r5_r  <= bus;
      if (R7in)   r7_r  <= bus;
    end
  end

`ifdef BUS_ONEHOT_CHECK_EN
  datapath_bus_chk u_bus_chk (
    .clock (clock),
    .clear (clear),
    .outs  ({MDRout, PCout, RZoutLo, RYout, IRout, MARout, R3out, R4out, R5out, R7out})
  );
`else
`endif

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus pushes expected bus values, a monitor pops and compares.
module tb_datapath;

  localparam int MDR = 0, PC = 1, ZL = 2, Y = 3, IR = 4, MAR = 5, R3 = 6, R4 = 7, R5 = 8, R7 = 9;

  logic        clock = 1'b0;
  logic        clear;
  logic [9:0]  out_m;
  logic [9:0]  in_m;
  logic        IncPC;
  logic        MDRread;
  logic [31:0] Mdatain;
  logic [31:0] bus;

  logic [31:0] m [10];
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic        obs = 1'b0;
  int          checks = 0;
  int          passes = 0;
  logic [4:0]  ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                            5'd17, 5'd18, 5'd0, 5'd31};

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .PCout(out_m[PC]), .MDRout(out_m[MDR]), .RZoutLo(out_m[ZL]), .RYout(out_m[Y]),
    .IRout(out_m[IR]), .MARout(out_m[MAR]), .R3out(out_m[R3]), .R4out(out_m[R4]),
    .R5out(out_m[R5]), .R7out(out_m[R7]),
    .PCin(in_m[PC]), .MDRin(in_m[MDR]), .MARin(in_m[MAR]), .IRin(in_m[IR]),
    .RYin(in_m[Y]), .RZinLo(in_m[ZL]), .R3in(in_m[R3]), .R4in(in_m[R4]),
    .R5in(in_m[R5]), .R7in(in_m[R7]),
    .IncPC(IncPC), .MDRread(MDRread), .Mdatain(Mdatain), .bus(bus)
  );

  function automatic logic [9:0] bm(input int i);
    logic [9:0] r;
    r = 10'd0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Reference ALU written from the operation table with plain arithmetic
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input logic inc);
    int unsigned s;
    logic [63:0] dbl;
    s = b[4:0];
    if (inc) return b + 32'd1;
    case (op)
      5'd3:    return a + b;
      5'd4:    return a - b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      5'd7:    return a >> s;
      5'd8:    begin dbl = {{32{a[31]}}, a} >> s; return dbl[31:0]; end
      5'd9:    return a << s;
      5'd10:   begin dbl = {a, a} >> s; return dbl[31:0]; end
      5'd11:   begin dbl = {a, a} << s; return dbl[63:32]; end
      5'd17:   return 32'd0 - b;
      5'd18:   return ~b;
      default: return b;
    endcase
  endfunction

  // One micro-step: predict the bus, queue it for the monitor, then apply loads to the model
  task automatic step(input logic [9:0] outs, input logic [9:0] ins, input logic inc,
                      input logic rd, input logic [31:0] md, input string tag);
    logic [31:0] b;
    logic [31:0] z;
    @(negedge clock);
    out_m = outs; in_m = ins; IncPC = inc; MDRread = rd; Mdatain = md;
    b = 32'd0;
    for (int i = 9; i >= 0; i--) if (outs[i]) b = m[i];
    z = alu_ref(m[Y], b, m[IR][31:27], inc);
    exp_q.push_back(b);
    tag_q.push_back(tag);
    obs = 1'b1;
    @(posedge clock);
    obs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ins[i]) begin
        if (i == MDR) m[i] = rd ? md : b;
        else if (i == ZL) m[i] = z;
        else m[i] = b;
      end
    end
  endtask

  task automatic ld_mdr(input logic [31:0] v, input string tag);
    step(10'd0, bm(MDR), 1'b0, 1'b1, v, tag);
  endtask

  task automatic mv(input int src, input logic [9:0] dst, input string tag);
    step(bm(src), dst, 1'b0, 1'b0, $urandom, tag);
  endtask

  task automatic rd(input int src, input string tag);
    step(bm(src), 10'd0, 1'b0, 1'b0, $urandom, tag);
  endtask

  task automatic set_ir(input logic [4:0] op, input string tag);
    ld_mdr({op, 27'($urandom)}, tag);
    mv(MDR, bm(IR), tag);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 10; i++) m[i] = 32'd0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 10; i++) rd(i, tag);
  endtask

  function automatic logic [9:0] rand_outs();
    if ($urandom_range(0, 3) == 0) return 10'($urandom);
    return bm(int'($urandom_range(0, 9)));
  endfunction

  // Monitor: compare the bus shortly before each edge of an observed step
  always @(negedge clock) begin
    logic [31:0] e;
    string t;
    #4;
    if (obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow: bus=%h with no expected value", bus);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (bus === e) passes++;
        else $display("FAIL %s: bus=%h expected %h", t, bus, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; out_m = '1; in_m = '1; IncPC = 1'b1; MDRread = 1'b1; Mdatain = 32'hFFFF_FFFF;
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    out_m = 10'd0; in_m = 10'd0; IncPC = 1'b0; MDRread = 1'b0;
    clear = 1'b1;
    read_all("reset_reg");
    step(10'd0, 10'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, "idle_bus");
    rd(PC, "reset_pcout");

    ld_mdr(32'h22, "ld_mdr_22");
    mv(MDR, bm(R5), "mdr_to_r5");
    rd(R5, "r5_22");

    step(bm(PC), bm(MAR) | bm(ZL), 1'b1, 1'b0, 32'd0, "pc_inc");
    rd(MAR, "mar_0");
    rd(ZL, "zlo_1");
    mv(ZL, bm(PC), "z_to_pc");
    rd(PC, "pc_1");

    ld_mdr(32'h922B_8000, "ld_not_instr");
    mv(MDR, bm(IR), "ir_not");
    rd(IR, "ir_value");
    mv(R5, bm(ZL), "not_r5");
    rd(ZL, "zlo_not");
    mv(ZL, bm(R5), "z_to_r5");
    rd(R5, "r5_not");

    ld_mdr(32'd5, "ld5"); mv(MDR, bm(R3), "r3_5");
    ld_mdr(32'd7, "ld7"); mv(MDR, bm(R4), "r4_7");
    mv(R3, bm(Y), "y_r3");
    set_ir(5'b00011, "ir_add");
    mv(R4, bm(ZL), "add"); rd(ZL, "zlo_add");
    set_ir(5'b00100, "ir_sub");
    mv(R4, bm(ZL), "sub"); rd(ZL, "zlo_sub");

    ld_mdr(32'h8000_0001, "ld_y"); mv(MDR, bm(Y), "y_set");
    ld_mdr(32'd1, "ld_1"); mv(MDR, bm(R7), "r7_1");
    foreach (ops[k]) begin
      set_ir(ops[k], "ir_op");
      mv(R7, bm(ZL), "alu_op");
      rd(ZL, "zlo_op");
    end

    mv(R5, bm(R5), "r5_self_load");
    rd(R5, "r5_hold");
    mv(ZL, bm(ZL) | bm(R3), "z_chain");
    rd(ZL, "z_chain_q");
    step(10'h3FF, 10'd0, 1'b0, 1'b0, 32'd0, "prio_all");
    step(10'h3FE, 10'd0, 1'b0, 1'b0, 32'd0, "prio_no_mdr");
    step(bm(R7) | bm(R3) | bm(MAR), 10'd0, 1'b0, 1'b0, 32'd0, "prio_low");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: ld_mdr($urandom, "rnd_ld_mdr");
        1: set_ir(ops[$urandom_range(0, 12)], "rnd_ir");
        2: step(rand_outs(), 10'($urandom) & 10'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom), $urandom, "rnd_step");
        default: rd(int'($urandom_range(0, 9)), "rnd_rd");
      endcase
    end
    read_all("rnd_final");

    @(negedge clock);
    out_m = bm(R5); in_m = bm(R3) | bm(ZL) | bm(MDR); MDRread = 1'b1; Mdatain = 32'hDEAD_BEEF;
    #2 clear = 1'b0;
    @(negedge clock);
    out_m = 10'd0; in_m = 10'd0; MDRread = 1'b0;
    clear = 1'b1;
    model_clear();
    read_all("midreset");

    @(negedge clock);
    out_m = 10'd0; in_m = 10'd0;
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_leftover: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
